// File: rtl/present_slot_scheduler.sv
// Fixed pool of falling-present sprite slots: allocates slots on drop requests,
// advances them once per frame, expires landed presents and reports pickups.
module present_slot_scheduler #(
    parameter int NUM_SLOTS  = 4,
    parameter int FALL_SPEED = 2,
    parameter int FLOOR_Y    = 440,
    parameter int LIFETIME   = 5
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   playmodeEnable,
    input  logic                   startOfFrame,
    input  logic                   secClk,
    input  logic                   dropReq,
    input  logic [10:0]            dropX,
    input  logic [10:0]            dropY,
    input  logic [1:0]             dropType,
    input  logic [NUM_SLOTS-1:0]   colSlotMask,
    output logic [NUM_SLOTS-1:0]   slotVisible,
    output logic [NUM_SLOTS*11-1:0] slotX,
    output logic [NUM_SLOTS*11-1:0] slotY,
    output logic [NUM_SLOTS*2-1:0] slotType,
    output logic                   col_present,
    output logic [1:0]             presentType,
    output logic                   dropDenied
);

    typedef enum logic [1:0] {
        S_FREE    = 2'd0,
        S_FALLING = 2'd1,
        S_LANDED  = 2'd2
    } slot_state_e;

    localparam logic [11:0] FLOOR_12   = 12'(FLOOR_Y);
    localparam logic [11:0] SPEED_12   = 12'(FALL_SPEED);
    localparam logic [2:0]  LIFE_LAST  = 3'(LIFETIME - 1);

    slot_state_e state_q [NUM_SLOTS];
    slot_state_e state_d [NUM_SLOTS];
    logic [10:0] x_q     [NUM_SLOTS];
    logic [10:0] x_d     [NUM_SLOTS];
    logic [10:0] y_q     [NUM_SLOTS];
    logic [10:0] y_d     [NUM_SLOTS];
    logic [1:0]  type_q  [NUM_SLOTS];
    logic [1:0]  type_d  [NUM_SLOTS];
    logic [2:0]  life_q  [NUM_SLOTS];
    logic [2:0]  life_d  [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] vis_q, vis_d;
    logic                 col_q, col_d;
    logic [1:0]           ptype_q, ptype_d;
    logic                 denied_q, denied_d;

    logic [NUM_SLOTS-1:0] drop_oh, pick_oh;
    logic                 drop_found, pick_found;
    logic [11:0]          fall_sum;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        drop_oh    = '0;
        pick_oh    = '0;
        drop_found = 1'b0;
        pick_found = 1'b0;
        fall_sum   = '0;
        col_d      = 1'b0;
        denied_d   = 1'b0;
        ptype_d    = ptype_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            x_d[i]     = x_q[i];
            y_d[i]     = y_q[i];
            type_d[i]  = type_q[i];
            life_d[i]  = life_q[i];
        end

        // Both searches look at start-of-cycle state, so a slot picked up now
        // cannot be reallocated until the following cycle.
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!drop_found && state_q[i] == S_FREE) begin
                drop_oh[i] = 1'b1;
                drop_found = 1'b1;
            end
            if (!pick_found && colSlotMask[i] && state_q[i] != S_FREE) begin
                pick_oh[i] = 1'b1;
                pick_found = 1'b1;
            end
        end

        if (!playmodeEnable) begin
            for (int i = 0; i < NUM_SLOTS; i++) state_d[i] = S_FREE;
        end else begin
            if (dropReq && !drop_found) denied_d = 1'b1;
            col_d = pick_found;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (dropReq && drop_oh[i]) begin
                    state_d[i] = S_FALLING;
                    x_d[i]     = dropX;
                    y_d[i]     = dropY;
                    type_d[i]  = dropType;
                    life_d[i]  = '0;
                end else if (pick_oh[i]) begin
                    state_d[i] = S_FREE;
                    ptype_d    = type_q[i];
                end else if (state_q[i] == S_LANDED && secClk) begin
                    if (life_q[i] == LIFE_LAST) state_d[i] = S_FREE;
                    else                        life_d[i]  = life_q[i] + 3'd1;
                end else if (state_q[i] == S_FALLING && startOfFrame) begin
                    fall_sum = {1'b0, y_q[i]} + SPEED_12;
                    if (fall_sum >= FLOOR_12) begin
                        y_d[i]     = 11'(FLOOR_Y);
                        state_d[i] = S_LANDED;
                    end else begin
                        y_d[i] = fall_sum[10:0];
                    end
                end
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) vis_d[i] = (state_d[i] != S_FREE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= S_FREE;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
                type_q[i]  <= '0;
                life_q[i]  <= '0;
            end
            vis_q    <= '0;
            col_q    <= 1'b0;
            ptype_q  <= '0;
            denied_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
                type_q[i]  <= type_d[i];
                life_q[i]  <= life_d[i];
            end
            vis_q    <= vis_d;
            col_q    <= col_d;
            ptype_q  <= ptype_d;
            denied_q <= denied_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign slotX[11*g +: 11]  = x_q[g];
        assign slotY[11*g +: 11]  = y_q[g];
        assign slotType[2*g +: 2] = type_q[g];
    end

    assign slotVisible = vis_q;
    assign col_present = col_q;
    assign presentType = ptype_q;
    assign dropDenied  = denied_q;

endmodule

// File: tb/tb_present_slot_scheduler.sv
// Directed bench for present_slot_scheduler with the default 4-slot configuration.
module tb_present_slot_scheduler;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              resetN;
    logic              playmodeEnable, startOfFrame, secClk, dropReq;
    logic [10:0]       dropX, dropY;
    logic [1:0]        dropType;
    logic [N-1:0]      colSlotMask;
    logic [N-1:0]      slotVisible;
    logic [N*11-1:0]   slotX, slotY;
    logic [N*2-1:0]    slotType;
    logic              col_present, dropDenied;
    logic [1:0]        presentType;

    int checks = 0;
    int errors = 0;

    present_slot_scheduler #(.NUM_SLOTS(N), .FALL_SPEED(2), .FLOOR_Y(440), .LIFETIME(5)) dut (
        .clk(clk), .resetN(resetN), .playmodeEnable(playmodeEnable),
        .startOfFrame(startOfFrame), .secClk(secClk), .dropReq(dropReq),
        .dropX(dropX), .dropY(dropY), .dropType(dropType), .colSlotMask(colSlotMask),
        .slotVisible(slotVisible), .slotX(slotX), .slotY(slotY), .slotType(slotType),
        .col_present(col_present), .presentType(presentType), .dropDenied(dropDenied)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input int i);
        return 32'(slotX[11*i +: 11]);
    endfunction
    function automatic logic [31:0] sy(input int i);
        return 32'(slotY[11*i +: 11]);
    endfunction
    function automatic logic [31:0] st(input int i);
        return 32'(slotType[2*i +: 2]);
    endfunction

    initial begin
        resetN = 1'b0; playmodeEnable = 1'b0; startOfFrame = 1'b0; secClk = 1'b0;
        dropReq = 1'b0; dropX = '0; dropY = '0; dropType = '0; colSlotMask = '0;
        #3;
        check("rst_vis", 32'(slotVisible), 0);
        check("rst_x", 32'(slotX), 0);
        check("rst_y", 32'(slotY), 0);
        check("rst_type", 32'(slotType), 0);
        check("rst_col", 32'(col_present), 0);
        check("rst_ptype", 32'(presentType), 0);
        check("rst_denied", 32'(dropDenied), 0);
        tick(); tick();

        // First drop
        resetN = 1'b1; playmodeEnable = 1'b1;
        dropReq = 1'b1; dropX = 11'd100; dropY = 11'd50; dropType = 2'b01;
        tick();
        dropReq = 1'b0;
        check("drop_vis", 32'(slotVisible), 32'b0001);
        check("drop_x0", sx(0), 100);
        check("drop_y0", sy(0), 50);
        check("drop_t0", st(0), 1);

        // Flush keeps coordinates
        playmodeEnable = 1'b0;
        tick();
        check("flush1_vis", 32'(slotVisible), 0);
        check("flush1_xhold", sx(0), 100);
        playmodeEnable = 1'b1;

        // Fall to the floor, then expire
        dropReq = 1'b1; dropX = 11'd7; dropY = 11'd436; dropType = 2'b10;
        tick();
        dropReq = 1'b0;
        check("fall_y_start", sy(0), 436);
        startOfFrame = 1'b1;
        tick();
        check("fall_y_438", sy(0), 438);
        tick();
        check("fall_y_440", sy(0), 440);
        tick();
        check("landed_y_hold", sy(0), 440);
        startOfFrame = 1'b0;
        secClk = 1'b1;
        tick(); tick(); tick(); tick();
        check("life4_vis", 32'(slotVisible), 32'b0001);
        tick();
        check("life5_vis", 32'(slotVisible), 0);
        check("expired_y_hold", sy(0), 440);
        secClk = 1'b0;

        // Five back-to-back drops into four slots
        dropReq = 1'b1;
        dropX = 11'd10; dropType = 2'b00; tick();
        check("b2b1_vis", 32'(slotVisible), 32'b0001);
        dropX = 11'd20; dropType = 2'b10; tick();
        check("b2b2_vis", 32'(slotVisible), 32'b0011);
        dropX = 11'd30; dropType = 2'b01; tick();
        check("b2b3_vis", 32'(slotVisible), 32'b0111);
        dropX = 11'd40; dropType = 2'b11; tick();
        check("b2b4_vis", 32'(slotVisible), 32'b1111);
        check("b2b4_denied", 32'(dropDenied), 0);
        dropX = 11'd50; tick();
        check("b2b5_vis", 32'(slotVisible), 32'b1111);
        check("b2b5_denied", 32'(dropDenied), 1);
        check("b2b5_x3", sx(3), 40);
        dropReq = 1'b0;
        tick();
        check("b2b_denied_end", 32'(dropDenied), 0);

        // Clear slots 0 and 2, leaving 1 (type 10) and 3 (type 11)
        colSlotMask = 4'b0101;
        tick();
        check("pk0_col", 32'(col_present), 1);
        check("pk0_type", 32'(presentType), 0);
        check("pk0_vis", 32'(slotVisible), 32'b1110);
        tick();
        check("pk2_type", 32'(presentType), 1);
        check("pk2_vis", 32'(slotVisible), 32'b1010);
        colSlotMask = 4'b1010;
        tick();
        check("pk1_col", 32'(col_present), 1);
        check("pk1_type", 32'(presentType), 2);
        check("pk1_vis", 32'(slotVisible), 32'b1000);
        tick();
        check("pk3_col", 32'(col_present), 1);
        check("pk3_type", 32'(presentType), 3);
        check("pk3_vis", 32'(slotVisible), 0);
        tick();
        check("pk_none_col", 32'(col_present), 0);
        colSlotMask = '0;

        // Pickup and drop in the same cycle with the pool full
        dropReq = 1'b1; dropType = 2'b00;
        tick(); tick(); tick(); tick();
        check("full_vis", 32'(slotVisible), 32'b1111);
        colSlotMask = 4'b0001;
        tick();
        check("same_denied", 32'(dropDenied), 1);
        check("same_col", 32'(col_present), 1);
        check("same_vis", 32'(slotVisible), 32'b1110);
        colSlotMask = '0; dropX = 11'd555;
        tick();
        dropReq = 1'b0;
        check("realloc_vis", 32'(slotVisible), 32'b1111);
        check("realloc_denied", 32'(dropDenied), 0);
        check("realloc_x0", sx(0), 555);

        // Flush with three occupied, then ignored drop
        colSlotMask = 4'b1000;
        tick();
        colSlotMask = '0;
        check("three_vis", 32'(slotVisible), 32'b0111);
        playmodeEnable = 1'b0;
        tick();
        check("flush2_vis", 32'(slotVisible), 0);
        dropReq = 1'b1; colSlotMask = 4'b0001;
        tick();
        check("flush_drop_denied", 32'(dropDenied), 0);
        check("flush_drop_vis", 32'(slotVisible), 0);
        check("flush_col", 32'(col_present), 0);
        colSlotMask = '0;

        // Asynchronous reset mid-operation
        playmodeEnable = 1'b1; dropX = 11'd9;
        tick();
        dropReq = 1'b0;
        check("pre_rst_vis", 32'(slotVisible), 32'b0001);
        resetN = 1'b0;
        #1;
        check("async_rst_vis", 32'(slotVisible), 0);
        check("async_rst_x", 32'(slotX), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
